// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC and IR of the multicycle core, fetching over a ready handshake with timeout
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        PCBEqCond,
    input  logic        PCBNqCond,
    input  logic [1:0]  PCSrc,
    input  logic        zero,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_out,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  func_field,
    output logic        ir_valid,
    output logic        stall,
    output logic        fetch_timeout
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic [15:0] pc_q, pc_d, pc_sel;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        timeout_q, timeout_d;
    logic        pc_en;
    // PC update: branch/jump/increment source with bit 0 forced low; select 11 holds
    always_comb begin
        pc_en  = PCWrite | (PCBEqCond & zero) | (PCBNqCond & ~zero);
        pc_sel = (PCSrc == 2'b00) ? alu_result :
                 (PCSrc == 2'b01) ? alu_out :
                 {pc_q[15:13], ir_q[11:0], 1'b0};
        pc_d   = (pc_en && PCSrc != 2'b11) ? (pc_sel & 16'hFFFE) : pc_q;
    end
    // Fetch FSM next state: latch old PC on start, load IR on ready or NOP on timeout
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        fetch_addr_d = fetch_addr_q;
        ir_d         = ir_q;
        ir_valid_d   = 1'b0;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (IRWrite) begin
                    fetch_addr_d = pc_q;
                    wait_cnt_d   = 8'd0;
                    state_d      = S_WAIT;
                end
            end
            default: begin
                if (imem_ready) begin
                    ir_d       = imem_data;
                    ir_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (wait_cnt_q == LAST_CNT) begin
                    ir_d       = 16'h0000;
                    ir_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
        endcase
    end
    // State registers with synchronous reset aborting any outstanding fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            fetch_addr_q <= 16'h0000;
            pc_q         <= RESET_PC;
            ir_q         <= 16'h0000;
            ir_valid_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            timeout_q    <= timeout_d;
        end
    end
    assign stall         = (state_q == S_WAIT);
    assign imem_req      = stall;
    assign imem_addr     = stall ? fetch_addr_q : 16'h0000;
    assign pc            = pc_q;
    assign ir            = ir_q;
    assign opcode        = ir_q[15:12];
    assign func_field    = ir_q[3:0];
    assign ir_valid      = ir_valid_q;
    assign fetch_timeout = timeout_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenario tests for instr_fetch_unit with TIMEOUT=4
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, IRWrite, PCWrite, PCBEqCond, PCBNqCond, zero, imem_ready;
    logic [1:0]  PCSrc;
    logic [15:0] alu_result, alu_out, imem_data;
    logic        imem_req, ir_valid, stall, fetch_timeout;
    logic [15:0] imem_addr, pc, ir;
    logic [3:0]  opcode, func_field;
    int          n_cmp = 0;
    int          n_bad = 0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCBEqCond(PCBEqCond), .PCBNqCond(PCBNqCond), .PCSrc(PCSrc), .zero(zero),
        .alu_result(alu_result), .alu_out(alu_out), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
        .pc(pc), .ir(ir), .opcode(opcode), .func_field(func_field),
        .ir_valid(ir_valid), .stall(stall), .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IRWrite = 0; PCWrite = 0; PCBEqCond = 0; PCBNqCond = 0; PCSrc = 2'b11;
        zero = 0; alu_result = 16'h0; alu_out = 16'h0; imem_data = 16'h0; imem_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc: got %h want 0000", pc); end
        n_cmp++; if (ir !== 16'h0000) begin n_bad++; $display("FAIL reset_ir: got %h want 0000", ir); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        n_cmp++; if ({ir_valid, fetch_timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {ir_valid, fetch_timeout}); end
    endtask

    task automatic test_zero_wait();
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h0002;
        tick();
        IRWrite = 0; PCWrite = 0; PCSrc = 2'b11; imem_ready = 1; imem_data = 16'h3A15;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_bad++; $display("FAIL zw_req_addr: got %b/%h want 1/0000", imem_req, imem_addr); end
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL zw_pc: got %h want 0002", pc); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL zw_valid_early: got %b want 0", ir_valid); end
        tick();
        imem_ready = 0;
        #1;
        n_cmp++; if (ir !== 16'h3A15) begin n_bad++; $display("FAIL zw_ir: got %h want 3a15", ir); end
        n_cmp++; if (opcode !== 4'b0011 || func_field !== 4'b0101) begin n_bad++; $display("FAIL zw_fields: got %b/%b want 0011/0101", opcode, func_field); end
        n_cmp++; if (ir_valid !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL zw_valid: got v%b s%b want v1 s0", ir_valid, stall); end
        tick();
        n_cmp++; if (ir_valid !== 1'b0 || ir !== 16'h3A15) begin n_bad++; $display("FAIL zw_pulse: got v%b ir %h want v0 ir 3a15", ir_valid, ir); end
    endtask

    task automatic test_wait_states();
        int n_stall, n_req, addr_bad;
        n_stall = 0; n_req = 0; addr_bad = 0;
        IRWrite = 1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (!stall) break;
            n_stall++;
            n_req += int'(imem_req);
            if (imem_addr !== 16'h0002) addr_bad++;
            IRWrite = (n_stall == 2);
            imem_ready = (n_stall == 4);
            imem_data = 16'h1234;
            tick();
        end
        IRWrite = 0; imem_ready = 0;
        #1;
        n_cmp++; if (n_stall !== 4) begin n_bad++; $display("FAIL ws_stall_cycles: got %0d want 4", n_stall); end
        n_cmp++; if (n_req !== 4) begin n_bad++; $display("FAIL ws_req_cycles: got %0d want 4", n_req); end
        n_cmp++; if (addr_bad !== 0) begin n_bad++; $display("FAIL ws_addr: got %0d bad cycles want 0", addr_bad); end
        n_cmp++; if (ir !== 16'h1234 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL ws_load: got %h v%b want 1234 v1", ir, ir_valid); end
        tick();
        n_cmp++; if (stall !== 1'b0 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL ws_no_queue: got s%b v%b want s0 v0", stall, ir_valid); end
    endtask

    task automatic test_branches();
        PCBEqCond = 1; zero = 1; PCSrc = 2'b01; alu_out = 16'h0040;
        tick();
        n_cmp++; if (pc !== 16'h0040) begin n_bad++; $display("FAIL beq_taken: got %h want 0040", pc); end
        zero = 0; alu_out = 16'h0080;
        tick();
        n_cmp++; if (pc !== 16'h0040) begin n_bad++; $display("FAIL beq_not_taken: got %h want 0040", pc); end
        PCBEqCond = 0; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h0010;
        tick();
        PCWrite = 0; PCBNqCond = 1; zero = 1; PCSrc = 2'b01; alu_out = 16'h0040;
        tick();
        n_cmp++; if (pc !== 16'h0010) begin n_bad++; $display("FAIL bne_not_taken: got %h want 0010", pc); end
        zero = 0;
        tick();
        n_cmp++; if (pc !== 16'h0040) begin n_bad++; $display("FAIL bne_taken: got %h want 0040", pc); end
        PCBNqCond = 0; PCWrite = 1; PCSrc = 2'b11; alu_result = 16'h7777; alu_out = 16'h7777;
        tick();
        n_cmp++; if (pc !== 16'h0040) begin n_bad++; $display("FAIL pcsrc_hold: got %h want 0040", pc); end
        PCSrc = 2'b00; alu_result = 16'h1235;
        tick();
        n_cmp++; if (pc !== 16'h1234) begin n_bad++; $display("FAIL pc_bit0: got %h want 1234", pc); end
        alu_result = 16'h8000;
        tick();
        PCWrite = 0; PCSrc = 2'b11; IRWrite = 1;
        tick();
        IRWrite = 0; imem_ready = 1; imem_data = 16'h2123;
        tick();
        imem_ready = 0;
        n_cmp++; if (ir !== 16'h2123 || pc !== 16'h8000) begin n_bad++; $display("FAIL jump_setup: got ir %h pc %h want 2123 8000", ir, pc); end
        PCWrite = 1; PCSrc = 2'b10;
        tick();
        PCWrite = 0; PCSrc = 2'b11;
        n_cmp++; if (pc !== 16'h8246) begin n_bad++; $display("FAIL jump: got %h want 8246", pc); end
    endtask

    task automatic test_timeout();
        int n_stall;
        n_stall = 0;
        IRWrite = 1;
        tick();
        IRWrite = 0; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            if (!stall) break;
            n_stall++;
            if (n_stall == 2) begin
                n_cmp++; if (imem_addr !== 16'h8246 || pc !== 16'h0100) begin n_bad++; $display("FAIL to_pc_during_wait: got addr %h pc %h want 8246 0100", imem_addr, pc); end
            end
            tick();
            PCWrite = 0;
        end
        n_cmp++; if (n_stall !== 4) begin n_bad++; $display("FAIL to_wait_cycles: got %0d want 4", n_stall); end
        n_cmp++; if (ir !== 16'h0000 || fetch_timeout !== 1'b1 || ir_valid !== 1'b1) begin n_bad++; $display("FAIL to_nop: got ir %h to %b v %b want 0000 1 1", ir, fetch_timeout, ir_valid); end
        tick(); tick();
        n_cmp++; if (fetch_timeout !== 1'b1 || stall !== 1'b0 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL to_sticky: got to %b s %b v %b want 1 0 0", fetch_timeout, stall, ir_valid); end
        imem_ready = 1; imem_data = 16'h5555;
        tick();
        imem_ready = 0;
        n_cmp++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ready_ignored: got ir %h v %b want 0000 0", ir, ir_valid); end
    endtask

    task automatic test_reset_mid_fetch();
        IRWrite = 1;
        tick();
        IRWrite = 0;
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rm_in_wait: got %b want 1", stall); end
        rst = 1;
        tick();
        rst = 0; imem_ready = 1; imem_data = 16'hBEEF;
        #1;
        n_cmp++; if (stall !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL rm_idle: got s%b r%b want s0 r0", stall, imem_req); end
        n_cmp++; if (pc !== 16'h0000 || fetch_timeout !== 1'b0) begin n_bad++; $display("FAIL rm_pc_flag: got pc %h to %b want 0000 0", pc, fetch_timeout); end
        tick();
        n_cmp++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin n_bad++; $display("FAIL rm_late_ready: got ir %h v %b want 0000 0", ir, ir_valid); end
        imem_ready = 0;
        tick();
        n_cmp++; if (ir_valid !== 1'b0 || ir !== 16'h0000) begin n_bad++; $display("FAIL rm_no_valid: got ir %h v %b want 0000 0", ir, ir_valid); end
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branches();
        test_timeout();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
